// File: rtl/debounced_input_pio_pkg.sv
// debounced_input_pio_pkg: register map, config bit positions and config struct
package debounced_input_pio_pkg;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_IRQ_MASK = 2'd1;
  localparam logic [1:0] REG_EDGE_CAPTURE = 2'd2;
  localparam logic [1:0] REG_CONFIG = 2'd3;
  localparam int CFG_RISE_EN = 0;
  localparam int CFG_FALL_EN = 1;
  typedef struct packed {
    logic fall_en;
    logic rise_en;
  } cfg_t;
endpackage

// File: rtl/debounced_input_pio_input_debounce.sv
// input_debounce: two-flop synchroniser and stability-count debouncer for one input bit
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic deb,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic sync1_q, sync2_q, deb_q, deb_d, flip;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    flip = (sync2_q != deb_q) && (cnt_q == LAST);
    deb_d = flip ? sync2_q : deb_q;
    cnt_d = (sync2_q == deb_q || flip) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end
  assign deb = deb_q;
  assign rise = flip & sync2_q;
  assign fall = flip & ~sync2_q;
endmodule

// File: rtl/debounced_input_pio.sv
// debounced_input_pio: debounced input PIO with edge capture and maskable irq on Avalon-MM
module debounced_input_pio
  import debounced_input_pio_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] pins_in,
  output logic [WIDTH-1:0] data_out
);
  logic [WIDTH-1:0] deb, rise, fall, new_edge, clr, mask_q, mask_d, edge_q, edge_d;
  logic [31:0] rdata_q, rdata_d;
  cfg_t cfg_q, cfg_d;
  logic unused_wd;
  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_bit
    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk(clk),
      .reset(reset),
      .pin(pins_in[i]),
      .deb(deb[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end
  always_comb begin
    new_edge = (rise & {WIDTH{cfg_q.rise_en}}) | (fall & {WIDTH{cfg_q.fall_en}});
    clr = (avs_write && avs_address == REG_EDGE_CAPTURE) ? avs_writedata[WIDTH-1:0] : '0;
    edge_d = (edge_q & ~clr) | new_edge;
    mask_d = (avs_write && avs_address == REG_IRQ_MASK) ? avs_writedata[WIDTH-1:0] : mask_q;
    cfg_d = (avs_write && avs_address == REG_CONFIG) ?
            '{fall_en: avs_writedata[CFG_FALL_EN], rise_en: avs_writedata[CFG_RISE_EN]} : cfg_q;
    rdata_d = !avs_read ? rdata_q :
              avs_address == REG_DATA ? 32'(deb) :
              avs_address == REG_IRQ_MASK ? 32'(mask_q) :
              avs_address == REG_EDGE_CAPTURE ? 32'(edge_q) : 32'(cfg_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      edge_q <= '0;
      cfg_q <= '0;
      rdata_q <= '0;
    end else begin
      mask_q <= mask_d;
      edge_q <= edge_d;
      cfg_q <= cfg_d;
      rdata_q <= rdata_d;
    end
  end
  assign avs_readdata = rdata_q;
  assign data_out = deb;
  assign irq = |(edge_q & mask_q);
  assign unused_wd = ^avs_writedata;
endmodule
